// File: rtl/instr_fetch_unit.sv
// Instruction fetch / next-PC stage: holds the PC, fetches one word at a time over a
// request/valid handshake, presents the latched instruction to the decoder and selects
// the next PC from Jump, Branch and Zero when the instruction leaves EXEC.
module instr_fetch_unit #(
  parameter int unsigned    DWL      = 32,
  parameter int unsigned    AWL      = 6,
  parameter logic [DWL-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           RST,
  output logic           IMReq,
  output logic [AWL-1:0] IMAddr,
  input  logic [DWL-1:0] IMRdata,
  input  logic           IMValid,
  input  logic           Branch,
  input  logic           Jump,
  input  logic           Zero,
  input  logic           Stall,
  output logic [DWL-1:0] Instr,
  output logic [5:0]     Opcode,
  output logic [DWL-1:0] PC,
  output logic [DWL-1:0] PCPlus4,
  output logic           InstrValid,
  output logic [31:0]    RetireCount
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StExec = 2'd3;

  logic [1:0]     r_state;
  logic [1:0]     w_state_next;
  logic [DWL-1:0] r_pc;
  logic [DWL-1:0] r_instr;
  logic [31:0]    r_retire;

  logic [DWL-1:0] w_pc_plus4;
  logic [DWL-1:0] w_br_offset;
  logic [DWL-1:0] w_jump_target;
  logic [DWL-1:0] w_next_pc;
  logic           w_retire;

  assign w_pc_plus4    = r_pc + DWL'(4);
  assign w_br_offset   = {{(DWL-18){r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jump_target = {w_pc_plus4[DWL-1:DWL-4], r_instr[25:0], 2'b00};
  assign w_retire      = (r_state == StExec) && !Stall;

  // Next-PC select; Jump is checked first so Branch is a don't-care during a jump.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Jump) begin
      w_next_pc = w_jump_target;
    end else if (Branch && Zero) begin
      w_next_pc = w_pc_plus4 + w_br_offset;
    end
  end

  // Fetch FSM next state; WAIT has no timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  w_state_next = StReq;
      StReq:   w_state_next = StWait;
      StWait:  if (IMValid) w_state_next = StExec;
      StExec:  if (!Stall) w_state_next = StReq;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC advances only when an instruction retires.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc <= RESET_PC;
    end else if (w_retire) begin
      r_pc <= w_next_pc;
    end
  end

  // Instruction latch; IMValid outside WAIT is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr <= '0;
    end else if ((r_state == StWait) && IMValid) begin
      r_instr <= IMRdata;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_retire <= '0;
    end else if (w_retire) begin
      r_retire <= r_retire + 32'd1;
    end
  end

  assign IMReq       = (r_state == StReq);
  assign IMAddr      = r_pc[AWL+1:2];
  assign InstrValid  = (r_state == StExec);
  assign Instr       = r_instr;
  assign Opcode      = r_instr[31:26];
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign RetireCount = r_retire;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Three instances share all inputs and differ only in
// RESET_PC (0, 0xFFFF_FFFC, 0x4000_0008) so that wrap and high-region jump cases can be
// observed without reprogramming the main instance.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] IMRdata;
  logic        IMValid;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic        Stall;

  logic        m_req,   w_req,   j_req;
  logic [5:0]  m_addr,  w_addr,  j_addr;
  logic [31:0] m_instr, w_instr, j_instr;
  logic [5:0]  m_op,    w_op,    j_op;
  logic [31:0] m_pc,    w_pc,    j_pc;
  logic [31:0] m_pcp4,  w_pcp4,  j_pcp4;
  logic        m_iv,    w_iv,    j_iv;
  logic [31:0] m_rc,    w_rc,    j_rc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_retire = 0;

  instr_fetch_unit #(.DWL(32), .AWL(6), .RESET_PC(32'h0000_0000)) u_main (
    .CLK(CLK), .RST(RST), .IMReq(m_req), .IMAddr(m_addr), .IMRdata(IMRdata),
    .IMValid(IMValid), .Branch(Branch), .Jump(Jump), .Zero(Zero), .Stall(Stall),
    .Instr(m_instr), .Opcode(m_op), .PC(m_pc), .PCPlus4(m_pcp4), .InstrValid(m_iv),
    .RetireCount(m_rc)
  );

  instr_fetch_unit #(.DWL(32), .AWL(6), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .RST(RST), .IMReq(w_req), .IMAddr(w_addr), .IMRdata(IMRdata),
    .IMValid(IMValid), .Branch(Branch), .Jump(Jump), .Zero(Zero), .Stall(Stall),
    .Instr(w_instr), .Opcode(w_op), .PC(w_pc), .PCPlus4(w_pcp4), .InstrValid(w_iv),
    .RetireCount(w_rc)
  );

  instr_fetch_unit #(.DWL(32), .AWL(6), .RESET_PC(32'h4000_0008)) u_jmp (
    .CLK(CLK), .RST(RST), .IMReq(j_req), .IMAddr(j_addr), .IMRdata(IMRdata),
    .IMValid(IMValid), .Branch(Branch), .Jump(Jump), .Zero(Zero), .Stall(Stall),
    .Instr(j_instr), .Opcode(j_op), .PC(j_pc), .PCPlus4(j_pcp4), .InstrValid(j_iv),
    .RetireCount(j_rc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Entered at a REQ-cycle negedge; returns at the following REQ-cycle negedge.
  task automatic do_instr(input logic [31:0] word, input int waits, input int stalls,
                          input bit spurious, input logic br, input logic jmp,
                          input logic zr, input logic [31:0] exp_pc,
                          input logic [31:0] exp_next);
    int t0;
    t0 = cyc;
    check("req_high", 32'(m_req), 32'd1);
    check("pc_at_req", m_pc, exp_pc);
    check("imaddr", 32'(m_addr), 32'(exp_pc[7:2]));
    check("pcplus4", m_pcp4, exp_pc + 32'd4);
    step();
    for (int i = 1; i < waits; i++) begin
      IMValid = 1'b0;
      check("req_in_wait", 32'(m_req), 32'd0);
      check("iv_in_wait", 32'(m_iv), 32'd0);
      step();
    end
    IMValid = 1'b1;
    IMRdata = word;
    step();
    IMValid = 1'b0;
    IMRdata = 32'hDEAD_BEEF;
    for (int s = 0; s < stalls; s++) begin
      check("stall_iv", 32'(m_iv), 32'd1);
      check("stall_req", 32'(m_req), 32'd0);
      check("stall_pc", m_pc, exp_pc);
      check("stall_rc", m_rc, 32'(exp_retire));
      Stall = 1'b1;
      step();
    end
    check("exec_iv", 32'(m_iv), 32'd1);
    check("exec_instr", m_instr, word);
    check("exec_opcode", 32'(m_op), 32'(word[31:26]));
    Stall  = 1'b0;
    Branch = br;
    Jump   = jmp;
    Zero   = zr;
    if (spurious) begin
      IMValid = 1'b1;
      IMRdata = ~word;
    end
    step();
    exp_retire++;
    IMValid = 1'b0;
    Branch  = 1'b0;
    Jump    = 1'b0;
    Zero    = 1'b0;
    check("next_pc", m_pc, exp_next);
    check("retire_cnt", m_rc, 32'(exp_retire));
    check("instr_kept", m_instr, word);
    check("iv_after", 32'(m_iv), 32'd0);
    check("next_req", 32'(m_req), 32'd1);
    check("instr_cycles", 32'(cyc - t0), 32'(2 + waits + stalls));
  endtask

  initial begin
    RST     = 1'b1;
    IMRdata = 32'h0;
    IMValid = 1'b0;
    Branch  = 1'b0;
    Jump    = 1'b0;
    Zero    = 1'b0;
    Stall   = 1'b0;

    @(negedge CLK);
    check("rst_req", 32'(m_req), 32'd0);
    check("rst_iv", 32'(m_iv), 32'd0);
    check("rst_pc", m_pc, 32'h0);
    check("rst_instr", m_instr, 32'h0);
    check("rst_opcode", 32'(m_op), 32'd0);
    check("rst_rc", m_rc, 32'd0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    @(negedge CLK);
    RST = 1'b0;
    check("idle_req", 32'(m_req), 32'd0);
    step();

    // Wrap instance: first fetch at top of address space, PC+4 wraps to 0.
    check("wrap_pc0", w_pc, 32'hFFFF_FFFC);
    check("wrap_addr0", 32'(w_addr), 32'd63);
    check("wrap_pcp4", w_pcp4, 32'h0);

    // Sequential non-branch fetches at 0,4,8,C.
    do_instr(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h04);
    check("wrap_pc1", w_pc, 32'h0);
    check("wrap_addr1", 32'(w_addr), 32'd0);
    do_instr(32'h2009_0007, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 32'h08);
    do_instr(32'h200A_0001, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0C);
    do_instr(32'h200B_0002, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h10);
    check("rc_after_12", m_rc, 32'd4);

    // Taken branch: 0x14 + (-4 << 2) = 0x04.
    do_instr(32'h1000_FFFC, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h04);
    // Three memory wait cycles plus a stray IMValid in EXEC.
    do_instr(32'h2008_0011, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h04, 32'h08);
    // Four stall cycles.
    do_instr(32'h2008_0022, 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0C);
    do_instr(32'h2008_0033, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h10);
    // Not-taken branch.
    do_instr(32'h1000_FFFC, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h14);

    // Asynchronous reset in WAIT with a response on the bus.
    check("pre_rst_pc", m_pc, 32'h14);
    step();
    IMValid = 1'b1;
    IMRdata = 32'h2008_0044;
    #2 RST = 1'b1;
    #1;
    check("arst_req", 32'(m_req), 32'd0);
    check("arst_iv", 32'(m_iv), 32'd0);
    check("arst_pc", m_pc, 32'h0);
    check("arst_instr", m_instr, 32'h0);
    check("arst_opcode", 32'(m_op), 32'd0);
    check("arst_rc", m_rc, 32'd0);
    @(negedge CLK);
    IMValid    = 1'b0;
    RST        = 1'b0;
    exp_retire = 0;
    check("restart_idle_req", 32'(m_req), 32'd0);
    check("restart_idle_iv", 32'(m_iv), 32'd0);
    step();

    // Jump with Branch unknown; high-region instance lands at 0x4000_0100.
    check("jmp_pc0", j_pc, 32'h4000_0008);
    do_instr(32'h0800_0040, 1, 0, 1'b0, 1'bx, 1'b1, 1'b0, 32'h00, 32'h100);
    check("jmp_pc1", j_pc, 32'h4000_0100);
    check("jmp_addr1", 32'(j_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and next-PC stage of the MIPS core. It holds the program counter and requests instructions from the instruction memory over a valid handshake. It latches each returned instruction and presents it, with its Opcode field, to the main decoder. It consumes the decoder's Branch and Jump outputs, plus the ALU Zero flag, to select the next PC.

## Interface
Parameters:
- DWL, 32, data/instruction/PC width
- AWL, 6, instruction memory word-address width (depth 2**AWL words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- IMReq  output  1  one-cycle instruction memory read request
- IMAddr  output  AWL  word address, = PC[AWL+1:2]
- IMRdata  input  DWL  instruction word returned by memory
- IMValid  input  1  IMRdata valid; sampled only in WAIT
- Branch  input  1  from main decoder
- Jump  input  1  from main decoder
- Zero  input  1  ALU zero flag for the current instruction
- Stall  input  1  hold current instruction in EXEC
- Instr  output  DWL  latched instruction
- Opcode  output  6  Instr[31:26], to main decoder
- PC  output  DWL  address of Instr
- PCPlus4  output  DWL  PC + 4
- InstrValid  output  1  Instr is executing this cycle; datapath qualifies RFWE/DMWE with it
- RetireCount  output  32  number of instructions retired

## Operation
- FSM states: IDLE, REQ, WAIT, EXEC.
  - IDLE -> REQ unconditionally on the first clock after reset.
  - REQ: IMReq=1, IMAddr=PC[AWL+1:2]. Always -> WAIT.
  - WAIT: if IMValid=1, Instr<=IMRdata and -> EXEC. Otherwise stay in WAIT, with no timeout.
  - EXEC: InstrValid=1.
    - Stall=1: stay in EXEC; PC, Instr and RetireCount hold.
    - Stall=0: PC<=NextPC, RetireCount<=RetireCount+1, -> REQ.
- NextPC priority, highest first:
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - Branch=1 and Zero=1: PCPlus4 + (sign-extended Instr[15:0] << 2), modulo 2**32.
  - Otherwise: PCPlus4.
- Jump takes priority, so an X on Branch during a jump does not affect the PC.
- All PC arithmetic is 32-bit unsigned and wraps. PC=32'hFFFF_FFFC gives PCPlus4=32'h0000_0000.
- PC[1:0] is always 0: RESET_PC must be word-aligned, and all targets are word-aligned by construction.
- IMAddr aliases modulo 2**AWL words. No fault is raised for addresses beyond the memory depth.
- IMValid in IDLE, REQ or EXEC is ignored. Only one request is ever outstanding.
- RetireCount wraps from 32'hFFFF_FFFF to 0.
- Opcode and PCPlus4 are combinational from the Instr and PC registers.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=IDLE, PC=RESET_PC, Instr=0, RetireCount=0
  - IMReq=0, InstrValid=0
  - Opcode=0 (consequence of Instr=0)
- The same reset values apply when RST asserts mid-operation, in any state.
- A response in flight at reset is discarded because the FSM leaves WAIT.
- Minimum 3 cycles per instruction (REQ, WAIT with IMValid the following cycle, EXEC). Each extra memory wait cycle adds 1.
- IMReq is high for exactly one cycle per instruction and never while in WAIT.
- Branch, Jump and Zero are sampled only on the EXEC clock edge where Stall=0.
- The PC update, RetireCount increment and the next IMReq all take effect on that same edge.
- InstrValid is high for every EXEC cycle, including stalled ones, and low otherwise.

## Test plan
- Reset/sequential:
  - Stimulus: RESET_PC=0; memory returns IMValid one cycle after each IMReq, with non-branch words (e.g. 32'h2008_0005 addi).
  - Required: IMAddr sequence 0,1,2,3; IMReq every 3rd cycle; RetireCount reaches 4 after 12 cycles.
- Wait states:
  - Stimulus: IMValid delayed 3 cycles; a spurious IMValid pulse during EXEC.
  - Required: the instruction takes 5 cycles and Instr is unchanged by the spurious pulse.
- Branch:
  - Stimulus: at PC=0x10, Instr=32'h1000_FFFC, Branch=1, Zero=1.
  - Required: next PC=0x04.
  - Stimulus: the same with Zero=0.
  - Required: next PC=0x14.
- Jump:
  - Stimulus: at PC=0x4000_0008, Instr=32'h0800_0040, Jump=1, Branch=X.
  - Required: next PC=0x4000_0100.
- Stall:
  - Stimulus: Stall=1 for 4 cycles in EXEC.
  - Required: InstrValid high for 5 cycles; PC and RetireCount held; no IMReq until Stall drops.
- Wrap/async reset:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Required: the second fetch is at PC=0 with IMAddr=0.
  - Stimulus: assert RST in the middle of WAIT.
  - Required: outputs take reset values before the next clock edge, and the FSM restarts from IDLE.
